// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//
// Two-requester round-robin arbiter that owns the select line of a shared
// 2:1 datapath mux. The current owner keeps the path while it requests; if
// the other side is waiting, the owner is forced off after MAX_HOLD
// consecutive contested cycles (MAX_HOLD = 0 removes that limit). The
// selected input is registered onto out together with out_valid.
//
// Parameters
//   WIDTH     data width of in_a, in_b and out
//   MAX_HOLD  contested cycles before a forced handover (0 = unlimited)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_a      in   requester A wants the path
//   req_b      in   requester B wants the path
//   in_a       in   data from requester A
//   in_b       in   data from requester B
//   gnt_a      out  A owns the path (registered)
//   gnt_b      out  B owns the path (registered)
//   sel        out  mux select, 0 = in_a, 1 = in_b (registered)
//   out        out  registered mux output
//   out_valid  out  out carries owned data this cycle
// ---------------------------------------------------------------------------
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CW     = $clog2(MAX_HOLD) + 1;
    localparam int LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [CW-1:0] HOLD_LAST = CW'(LAST_I);
    localparam logic [CW-1:0] HOLD_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_hold_cnt;
    logic [CW-1:0]   w_hold_next;
    logic            r_last_b;      // 1 = B owned most recently
    logic            w_last_b_next;
    logic            r_gnt_a;
    logic            r_gnt_b;
    logic            r_sel;
    logic [WIDTH-1:0] r_out;
    logic            r_out_valid;
    logic            w_other_req;
    logic            w_limit;
    logic [WIDTH-1:0] w_mux;

    // Request of whichever side does not currently own the path.
    assign w_other_req = (r_state == OWN_A) ? req_b :
                         (r_state == OWN_B) ? req_a : 1'b0;

    // Owner has used up its contested budget this cycle.
    assign w_limit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = '0;
        w_last_b_next = r_last_b;

        case (r_state)
            IDLE: begin
                if (req_a && req_b)
                    w_state_next = r_last_b ? OWN_A : OWN_B;
                else if (req_a)
                    w_state_next = OWN_A;
                else if (req_b)
                    w_state_next = OWN_B;
                else
                    w_state_next = IDLE;
            end
            OWN_A: begin
                if (!req_a)
                    w_state_next = req_b ? OWN_B : IDLE;
                else if (req_b && w_limit)
                    w_state_next = OWN_B;
                else
                    w_state_next = OWN_A;
            end
            OWN_B: begin
                if (!req_b)
                    w_state_next = req_a ? OWN_A : IDLE;
                else if (req_a && w_limit)
                    w_state_next = OWN_A;
                else
                    w_state_next = OWN_B;
            end
            default: w_state_next = IDLE;
        endcase

        // Counter only runs while the owner stays put under contention;
        // saturating keeps the unlimited configuration from wrapping.
        if ((w_state_next == r_state) && (r_state != IDLE) && w_other_req)
            w_hold_next = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

        if ((w_state_next == OWN_A) && (r_state != OWN_A))
            w_last_b_next = 1'b0;
        else if ((w_state_next == OWN_B) && (r_state != OWN_B))
            w_last_b_next = 1'b1;
    end

    // Control registers: grant/select are registered from the next state so
    // they always equal a decode of r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_last_b   <= 1'b1;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_last_b   <= w_last_b_next;
            r_gnt_a    <= (w_state_next == OWN_A);
            r_gnt_b    <= (w_state_next == OWN_B);
            r_sel      <= (w_state_next == OWN_B);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign w_mux[gi] = r_sel ? in_b[gi] : in_a[gi];
        end
    endgenerate

    // Data lags the grant by one cycle; out holds its last owned value
    // whenever nobody owns the path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_gnt_a | r_gnt_b;
            if (r_gnt_a | r_gnt_b)
                r_out <= w_mux;
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
//
// Three arbiters (MAX_HOLD = 8, 0, 1) share one set of inputs. A directed
// vector table exercises the MAX_HOLD = 8 instance, short hand-written
// sequences cover rotation and the unlimited-hold case, and a randomized
// phase compares all three instances against an owner/turn reference model.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_a, req_b;
    logic [W-1:0] in_a, in_b;

    logic         ga8, gb8, s8, v8;
    logic [W-1:0] o8;
    logic         ga0, gb0, s0, v0;
    logic [W-1:0] o0;
    logic         ga1, gb1, s1, v1;
    logic [W-1:0] o1;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .in_a(in_a), .in_b(in_b), .gnt_a(ga8), .gnt_b(gb8), .sel(s8),
        .out(o8), .out_valid(v8));

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .in_a(in_a), .in_b(in_b), .gnt_a(ga0), .gnt_b(gb0), .sel(s0),
        .out(o0), .out_valid(v0));

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .in_a(in_a), .in_b(in_b), .gnt_a(ga1), .gnt_b(gb1), .sel(s1),
        .out(o1), .out_valid(v1));

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = A, 2 = B. served = contested cycles the current
    // owner has already used; the owner must yield on its mh-th one.
    int       mh     [3] = '{8, 0, 1};
    int       owner  [3];
    int       last   [3];
    int       served [3];
    int       m_out  [3];
    int       m_ov   [3];

    task automatic model_edge();
        bit rq [3];
        int nw, y;
        rq[0] = 1'b0; rq[1] = req_a; rq[2] = req_b;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                owner[i] = 0; last[i] = 2; served[i] = 0;
                m_out[i] = 0; m_ov[i] = 0;
            end else begin
                if (owner[i] == 1) m_out[i] = int'(in_a);
                if (owner[i] == 2) m_out[i] = int'(in_b);
                m_ov[i] = (owner[i] != 0) ? 1 : 0;
                if (owner[i] == 0) begin
                    if (req_a && req_b) nw = (last[i] == 1) ? 2 : 1;
                    else if (req_a)     nw = 1;
                    else if (req_b)     nw = 2;
                    else                nw = 0;
                end else begin
                    y = 3 - owner[i];
                    if (!rq[owner[i]])                           nw = rq[y] ? y : 0;
                    else if (rq[y] && mh[i] != 0 && served[i] + 1 >= mh[i]) nw = y;
                    else                                         nw = owner[i];
                end
                if (nw != owner[i])               served[i] = 0;
                else if (nw != 0 && rq[3 - nw])   served[i] = served[i] + 1;
                else                              served[i] = 0;
                if (nw != 0 && nw != owner[i]) last[i] = nw;
                owner[i] = nw;
            end
        end
    endtask

    function automatic logic [7:0] model_vec(int i);
        logic [7:0] v;
        v[7]   = (owner[i] == 1);
        v[6]   = (owner[i] == 2);
        v[5]   = (owner[i] == 2);
        v[4]   = (m_ov[i] != 0);
        v[3:0] = 4'(m_out[i]);
        return v;
    endfunction

    function automatic logic [7:0] dut_vec(int i);
        case (i)
            0:       return {ga8, gb8, s8, v8, o8};
            1:       return {ga0, gb0, s0, v0, o0};
            default: return {ga1, gb1, s1, v1, o1};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: predict, advance, compare every instance with the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("model[mh=%0d] {ga,gb,sel,ov,out}", mh[i]),
                  32'(dut_vec(i)), 32'(model_vec(i)));
        check("no_double_grant", 32'((ga8 & gb8) | (ga0 & gb0) | (ga1 & gb1)), 32'd0);
    endtask

    // ---------------- directed table (MAX_HOLD = 8 instance) ----------------
    typedef struct {
        bit           rst;
        bit           ra, rb;
        logic [W-1:0] ia, ib;
        bit           ega, egb, eov;
        logic [W-1:0] eout;
    } vec_t;

    vec_t tbl [18];

    initial begin
        //           rst ra rb  ia    ib    ga gb ov  out
        tbl[0]  = '{1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0};
        tbl[1]  = '{0, 1, 0, 4'h1, 4'h0, 1, 0, 0, 4'h0};
        tbl[2]  = '{0, 1, 0, 4'h1, 4'h0, 1, 0, 1, 4'h1};
        tbl[3]  = '{0, 0, 0, 4'h5, 4'h0, 0, 0, 1, 4'h5};
        tbl[4]  = '{0, 0, 0, 4'h2, 4'h3, 0, 0, 0, 4'h5};
        tbl[5]  = '{1, 1, 1, 4'h3, 4'h9, 0, 0, 0, 4'h0};
        tbl[6]  = '{0, 1, 1, 4'h3, 4'h9, 1, 0, 0, 4'h0};
        tbl[7]  = '{0, 0, 1, 4'h3, 4'h9, 0, 1, 1, 4'h3};
        tbl[8]  = '{0, 0, 1, 4'h3, 4'h9, 0, 1, 1, 4'h9};
        tbl[9]  = '{0, 0, 0, 4'h2, 4'h6, 0, 0, 1, 4'h6};
        tbl[10] = '{0, 0, 0, 4'h2, 4'h6, 0, 0, 0, 4'h6};
        tbl[11] = '{0, 0, 1, 4'h0, 4'h4, 0, 1, 0, 4'h6};
        tbl[12] = '{0, 0, 0, 4'h0, 4'h7, 0, 0, 1, 4'h7};
        tbl[13] = '{0, 0, 1, 4'h0, 4'h8, 0, 1, 0, 4'h7};
        tbl[14] = '{0, 0, 1, 4'h0, 4'h8, 0, 1, 1, 4'h8};
        tbl[15] = '{1, 1, 1, 4'hA, 4'hB, 0, 0, 0, 4'h0};
        tbl[16] = '{0, 1, 1, 4'hA, 4'hB, 1, 0, 0, 4'h0};
        tbl[17] = '{0, 1, 1, 4'hA, 4'hB, 1, 0, 1, 4'hA};

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; in_a = '0; in_b = '0;

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb;
            in_a  = tbl[i].ia;  in_b  = tbl[i].ib;
            step();
            check($sformatf("vec%0d gnt_a", i), 32'(ga8), 32'(tbl[i].ega));
            check($sformatf("vec%0d gnt_b", i), 32'(gb8), 32'(tbl[i].egb));
            check($sformatf("vec%0d sel", i),   32'(s8),  32'(tbl[i].egb));
            check($sformatf("vec%0d out_valid", i), 32'(v8), 32'(tbl[i].eov));
            check($sformatf("vec%0d out", i),   32'(o8),  32'(tbl[i].eout));
            $display("vec %0d: rst=%0d ra=%0d rb=%0d -> ga=%0d gb=%0d ov=%0d out=%0h",
                     i, tbl[i].rst, tbl[i].ra, tbl[i].rb, ga8, gb8, v8, o8);
        end

        // ---- sustained contention: 8/8 rotation, unlimited, every-cycle ----
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        step();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            in_a = W'($urandom); in_b = W'($urandom);
            step();
            check($sformatf("rot8 k=%0d gnt_a", k), 32'(ga8), 32'(((k - 1) / 8) % 2 == 0));
            check($sformatf("rot8 k=%0d gnt_b", k), 32'(gb8), 32'(((k - 1) / 8) % 2 == 1));
            check($sformatf("rot1 k=%0d gnt_a", k), 32'(ga1), 32'((k - 1) % 2 == 0));
            check($sformatf("hold0 k=%0d gnt_a", k), 32'(ga0), 32'd1);
            $display("contend k=%0d: mh8 ga=%0d gb=%0d | mh1 ga=%0d | mh0 ga=%0d",
                     k, ga8, gb8, ga1, ga0);
        end

        // ---- unlimited hold: A yields only when it drops ----
        req_a = 1'b0; req_b = 1'b1;
        step();
        check("hold0 drop_a gnt_b", 32'(gb0), 32'd1);
        $display("hold0 drop A: ga=%0d gb=%0d", ga0, gb0);
        req_a = 1'b0; req_b = 1'b0;
        step();
        check("hold0 idle gnt", 32'({ga0, gb0}), 32'd0);
        $display("hold0 idle: ga=%0d gb=%0d", ga0, gb0);
        req_a = 1'b1; req_b = 1'b1;
        step();
        check("hold0 tie_after_b gnt_a", 32'(ga0), 32'd1);
        $display("hold0 tie: ga=%0d gb=%0d", ga0, gb0);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            req_a = ($urandom_range(0, 3) != 0);
            req_b = ($urandom_range(0, 3) != 0);
            in_a  = W'($urandom);
            in_b  = W'($urandom);
            step();
            $display("rand %0d: rst=%0d ra=%0d rb=%0d | mh8 %02h mh0 %02h mh1 %02h",
                     k, reset, req_a, req_b, dut_vec(0), dut_vec(1), dut_vec(2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
